// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Gate-level 1-bit full adder; the only arithmetic element of the serial adder datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic prop;
    logic gen;
    logic prop_carry;

    xor x_prop (prop, a, b);
    xor x_sum  (sum, prop, ci);
    and a_gen  (gen, a, b);
    and a_prop (prop_carry, prop, ci);
    or  o_co   (co, gen, prop_carry);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: operands shift LSB-first through one full_adder_cell while the
// controller holds the carry, counts bits and presents the result on a valid/ready handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic load;
    logic shift;
    logic cancel;

    logic fa_sum;
    logic fa_co;

    full_adder_cell u_fa (
        .a   (a_sh_reg[0]),
        .b   (b_sh_reg[0]),
        .ci  (carry_reg),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // abort takes priority over out_ready in DONE, so a simultaneous pair counts as cancelled.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        cancel     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cancel     = 1'b1;
                    state_next = IDLE;
                end else begin
                    shift = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    cancel     = 1'b1;
                    state_next = IDLE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else if (load) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            sum_sh_reg <= '0;
            carry_reg  <= ci;
            cnt_reg    <= '0;
        end else if (cancel) begin
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (shift) begin
            a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
            sum_sh_reg <= {fa_sum, sum_sh_reg[WIDTH-1:1]};
            carry_reg  <= fa_co;
            cnt_reg    <= cnt_reg + CNT_ONE;
        end
    end

    // Result outputs are gated to DONE so partial sums during RUN are never visible.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DONE);
        sum       = '0;
        co        = 1'b0;
        if (state_reg == DONE) begin
            sum = sum_sh_reg;
            co  = carry_reg;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table plus hand-written handshake corner cases.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         busy;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   checks;
    int   errors;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one operand set at a negedge, pushes its expected result, and confirms the load.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                            input logic [W-1:0] es, input logic ec);
        exp_t e;
        chk("in_ready_before_load", in_ready, 1);
        a = av; b = bv; ci = cv; in_valid = 1'b1;
        e.s = es; e.c = ec;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_load", busy, 1);
        chk("in_ready_in_run", in_ready, 0);
        $display("op a=%02h b=%02h ci=%0d loaded, expect sum=%02h co=%0d", av, bv, cv, es, ec);
    endtask

    task automatic wait_result();
        int lat;
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(negedge clk);
            lat++;
        end
        chk("result_latency", lat, W);
    endtask

    task automatic deliver();
        exp_t e;
        chk("out_valid_at_deliver", out_valid, 1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: result sum=%02h co=%0d with nothing expected", sum, co);
        end else begin
            e = exp_q.pop_front();
            chk("sum", sum, e.s);
            chk("co", co, e.c);
            $display("result sum=%02h co=%0d expected sum=%02h co=%0d", sum, co, e.s, e.c);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_accept", out_valid, 0);
        chk("in_ready_after_accept", in_ready, 1);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
        return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    endfunction

    initial begin
        logic [W:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        exp_t held;
        int seen;

        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
        abort = 1'b0; out_ready = 1'b0;

        vecs[0] = '{a: 8'h35, b: 8'h4A, ci: 1'b0, s: 8'h7F, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, c: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, ci: 1'b0, s: 8'h00, c: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, c: 1'b1};
        vecs[4] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, c: 1'b1};
        vecs[5] = '{a: 8'h0F, b: 8'hF0, ci: 1'b1, s: 8'h00, c: 1'b1};
        vecs[6] = '{a: 8'hAA, b: 8'h55, ci: 1'b0, s: 8'hFF, c: 1'b0};
        vecs[7] = '{a: 8'h12, b: 8'h34, ci: 1'b1, s: 8'h47, c: 1'b0};

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].c);
            wait_result();
            deliver();
        end

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            m = model(ra, rb, rc);
            start_op(ra, rb, rc, m[W-1:0], m[W]);
            wait_result();
            deliver();
        end

        // Backpressure: result held, new operands ignored until the cycle after acceptance
        start_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        wait_result();
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'hF0; b = 8'h0F; ci = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum_held", sum, held.s);
            chk("bp_co_held", co, held.c);
        end
        a = 8'h12; b = 8'h34; ci = 1'b1;
        deliver();
        begin
            exp_t e;
            e.s = 8'h47; e.c = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accepted", busy, 1);
        wait_result();
        deliver();

        // Abort at the 3rd RUN edge
        start_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_run_in_ready", in_ready, 1);
        chk("abort_run_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("abort_run_no_output", seen, 0);
        $display("abort in RUN: returned to idle, output cycles seen=%0d", seen);
        start_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        wait_result();
        deliver();

        // Abort in IDLE does not block a handshake on the same edge
        abort = 1'b1;
        start_op(8'h21, 8'h43, 1'b1, 8'h65, 1'b0);
        abort = 1'b0;
        wait_result();
        deliver();

        // Abort together with out_ready in DONE: cancelled, not delivered
        start_op(8'h33, 8'h44, 1'b0, 8'h77, 1'b0);
        wait_result();
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_done_out_valid", out_valid, 0);
        chk("abort_done_in_ready", in_ready, 1);
        chk("abort_done_carry_clear", dut.carry_reg, 0);
        $display("abort in DONE with out_ready: out_valid=%0d", out_valid);

        // Asynchronous reset mid-RUN
        start_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_out_valid", out_valid, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("async_rst_no_stale", seen, 0);
        $display("reset mid-RUN: stale output cycles seen=%0d", seen);
        start_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        wait_result();
        deliver();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
